// File: rtl/pwm_preconditioner_pkg.sv
// rtl/pwm_preconditioner_pkg.sv - shared defaults, FSM states and RAM word layout
package pwm_preconditioner_pkg;

  localparam int WIDTH_DEF     = 13;
  localparam int TRANS_NUM_DEF = 249;
  localparam int IDX_W_DEF     = 8;
  localparam int RAM_LAT_DEF   = 2;

  // RAM word is {PHASE, DUTY}: duty in the low field, phase directly above it
  localparam int DUTY_OFS = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int phase_ofs(input int width);
    return DUTY_OFS + width;
  endfunction

endpackage

// File: rtl/pwm_preconditioner_if.sv
// rtl/pwm_preconditioner_if.sv - RAM read port and edge result stream
interface pwm_preconditioner_if
  import pwm_preconditioner_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = IDX_W_DEF
);

  logic [IDX_W-1:0]   RAM_ADDR;
  logic [2*WIDTH-1:0] RAM_DATA;
  logic               OUT_VALID;
  logic [IDX_W-1:0]   OUT_IDX;
  logic [WIDTH-1:0]   LEFT;
  logic [WIDTH-1:0]   RIGHT;
  logic               OVER;

  modport master (
    output RAM_ADDR,
    input  RAM_DATA,
    output OUT_VALID,
    output OUT_IDX,
    output LEFT,
    output RIGHT,
    output OVER
  );

  modport slave (
    input  RAM_ADDR,
    output RAM_DATA,
    input  OUT_VALID,
    input  OUT_IDX,
    input  LEFT,
    input  RIGHT,
    input  OVER
  );

endinterface

// File: rtl/pwm_edge_calc.sv
// rtl/pwm_edge_calc.sv - three-stage (duty, phase) to (left, right, over) pipeline
module pwm_edge_calc
  import pwm_preconditioner_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [WIDTH-1:0]   cycle,
  input  logic               in_valid,
  input  logic [IDX_W-1:0]   in_idx,
  input  logic [2*WIDTH-1:0] in_data,
  output logic               out_valid,
  output logic [IDX_W-1:0]   out_idx,
  output logic [WIDTH-1:0]   left,
  output logic [WIDTH-1:0]   right,
  output logic               over
);

  localparam int PHASE_OFS = phase_ofs(WIDTH);

  logic [WIDTH-1:0] duty, phase, d_clip, h_lo, h_hi;

  logic             v1_q;
  logic [IDX_W-1:0] idx1_q;
  logic [WIDTH-1:0] p1_q, hlo1_q, hhi1_q;

  logic                    v2_q;
  logic [IDX_W-1:0]        idx2_q;
  logic signed [WIDTH+1:0] l2_q, r2_q;

  logic signed [WIDTH+1:0] c_ext;
  logic [WIDTH-1:0]        left_d, right_d;
  logic                    over_d;

  assign c_ext = $signed({2'b00, cycle});

  // S1 combinational: clamp duty to the period and split it around the phase centre
  always_comb begin
    duty   = in_data[DUTY_OFS +: WIDTH];
    phase  = in_data[PHASE_OFS +: WIDTH];
    d_clip = (duty > cycle) ? cycle : duty;
    h_lo   = d_clip >> 1;
    h_hi   = d_clip - h_lo;
  end

  // S1 register: halves, phase, valid and index
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v1_q   <= 1'b0;
      idx1_q <= '0;
      p1_q   <= '0;
      hlo1_q <= '0;
      hhi1_q <= '0;
    end else begin
      v1_q   <= in_valid;
      idx1_q <= in_idx;
      p1_q   <= phase;
      hlo1_q <= h_lo;
      hhi1_q <= h_hi;
    end
  end

  // S2 register: raw edges, widened so negative and beyond-period values survive
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v2_q   <= 1'b0;
      idx2_q <= '0;
      l2_q   <= '0;
      r2_q   <= '0;
    end else begin
      v2_q   <= v1_q;
      idx2_q <= idx1_q;
      l2_q   <= $signed({2'b00, p1_q}) - $signed({2'b00, hlo1_q});
      r2_q   <= $signed({2'b00, p1_q}) + $signed({2'b00, hhi1_q});
    end
  end

  // S3 combinational: fold whichever edge fell outside [0, cycle) back into range
  always_comb begin
    left_d  = l2_q[WIDTH-1:0];
    right_d = r2_q[WIDTH-1:0];
    over_d  = 1'b0;
    if (l2_q[WIDTH+1]) begin
      left_d = WIDTH'(l2_q + c_ext);
      over_d = 1'b1;
    end else if (r2_q >= c_ext) begin
      right_d = WIDTH'(r2_q - c_ext);
      over_d  = 1'b1;
    end
  end

  // S3 register: results update only with valid data and otherwise hold
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      left      <= '0;
      right     <= '0;
      over      <= 1'b0;
    end else begin
      out_valid <= v2_q;
      if (v2_q) begin
        out_idx <= idx2_q;
        left    <= left_d;
        right   <= right_d;
        over    <= over_d;
      end
    end
  end

endmodule

// File: rtl/pwm_preconditioner.sv
// rtl/pwm_preconditioner.sv - per-frame RAM walk feeding the edge pipeline
module pwm_preconditioner
  import pwm_preconditioner_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int TRANS_NUM = TRANS_NUM_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int RAM_LAT   = RAM_LAT_DEF  // at least 1: the RAM is registered
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] CYCLE,
  output logic             BUSY,
  output logic             DONE,
  pwm_preconditioner_if.master bus
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(TRANS_NUM - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] cycle_q;
  logic             done_q, done_d;
  logic             issue;

  logic [RAM_LAT-1:0] dly_v;
  logic [IDX_W-1:0]   dly_idx [RAM_LAT];

  // Frame state, address counter, latched period and done pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cycle_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      if (state_q == ST_IDLE && START) cycle_q <= CYCLE;
    end
  end

  // Next state: one address per clock while fetching, then wait for the last result
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          addr_d  = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        issue = 1'b1;
        if (addr_q == LAST) state_d = ST_DRAIN;
        else                addr_d  = addr_q + 1'b1;
      end
      ST_DRAIN: begin
        done_d = bus.OUT_VALID && (bus.OUT_IDX == LAST);
        if (done_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Carry valid and index alongside the RAM read so they meet its data
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dly_v <= '0;
      for (int i = 0; i < RAM_LAT; i++) dly_idx[i] <= '0;
    end else begin
      dly_v[0]   <= issue;
      dly_idx[0] <= addr_q;
      for (int i = 1; i < RAM_LAT; i++) begin
        dly_v[i]   <= dly_v[i-1];
        dly_idx[i] <= dly_idx[i-1];
      end
    end
  end

  assign bus.RAM_ADDR = addr_q;
  assign BUSY         = (state_q != ST_IDLE);
  assign DONE         = done_q;

  pwm_edge_calc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_edge_calc (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .cycle     (cycle_q),
    .in_valid  (dly_v[RAM_LAT-1]),
    .in_idx    (dly_idx[RAM_LAT-1]),
    .in_data   (bus.RAM_DATA),
    .out_valid (bus.OUT_VALID),
    .out_idx   (bus.OUT_IDX),
    .left      (bus.LEFT),
    .right     (bus.RIGHT),
    .over      (bus.OVER)
  );

endmodule

// File: tb/tb_pwm_preconditioner.sv
// tb/tb_pwm_preconditioner.sv - randomized frames against a behavioural edge model
module tb_pwm_preconditioner;
  import pwm_preconditioner_pkg::*;

  localparam int W     = 13;
  localparam int N     = 249;
  localparam int LAT   = 2;
  localparam int FIRST = LAT + 4;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         START;
  logic [W-1:0] CYCLE;
  logic         BUSY;
  logic         DONE;

  pwm_preconditioner_if bus ();

  pwm_preconditioner dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .CYCLE (CYCLE),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // duty/phase RAM with two registered read stages
  logic [2*W-1:0] mem [0:N-1];
  logic [2*W-1:0] rd0, rd1;
  always @(posedge CLK) begin
    rd0 <= mem[bus.RAM_ADDR];
    rd1 <= rd0;
  end
  assign bus.RAM_DATA = rd1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int c, input int d, input int p,
                                output int l, output int r, output int o);
    int dp, lo, hi, lr, rr;
    dp = (d < c) ? d : c;
    lo = dp / 2;
    hi = dp - lo;
    lr = p - lo;
    rr = p + hi;
    if (lr < 0)       begin l = lr + c; r = rr;     o = 1; end
    else if (rr >= c) begin l = lr;     r = rr - c; o = 1; end
    else              begin l = lr;     r = rr;     o = 0; end
  endfunction

  int ref_d [N];
  int ref_p [N];

  task automatic fill_random(input int c);
    int d, p, k;
    for (int i = 0; i < N; i++) begin
      k = $urandom_range(7, 0);
      if (k == 0)      d = 0;
      else if (k == 1) d = $urandom_range(8191, c);
      else             d = $urandom_range(c, 0);
      p = $urandom_range(c - 1, 0);
      ref_d[i] = d;
      ref_p[i] = p;
      mem[i] = {p[W-1:0], d[W-1:0]};
    end
  endtask

  int dir_d [5] = '{0, 2048, 1000, 1001, 5000};
  int dir_p [5] = '{100, 2048, 100, 4000, 0};
  int dir_l [5] = '{100, 1024, 3696, 3500, 2048};
  int dir_r [5] = '{100, 3072, 600, 405, 2048};
  int dir_o [5] = '{0, 0, 1, 1, 1};

  task automatic fill_directed();
    int d, p;
    fill_random(4096);
    for (int i = 0; i < 5; i++) begin
      d = dir_d[i];
      p = dir_p[i];
      ref_d[i] = d;
      ref_p[i] = p;
      mem[i] = {p[W-1:0], d[W-1:0]};
    end
  endtask

  // mode 0: plain frame, 1: START + CYCLE change mid-frame, 2: reset at index 50
  task automatic run_frame(input int c, input int mode, input bit directed);
    int l, r, o, idx, last_l, last_r, last_o;
    bit exp_v;
    last_l = 0; last_r = 0; last_o = 0;
    @(negedge CLK);
    START = 1'b1;
    CYCLE = c[W-1:0];
    @(negedge CLK);
    START = 1'b0;
    for (int t = 1; t <= FIRST + N + 3; t++) begin
      exp_v = (t >= FIRST) && (t < FIRST + N);
      chk("out_valid", int'(bus.OUT_VALID), int'(exp_v));
      chk("busy", int'(BUSY), int'(t <= FIRST + N));
      chk("done", int'(DONE), int'(t == FIRST + N));
      if (t <= N) chk("ram_addr", int'(bus.RAM_ADDR), t - 1);
      if (exp_v) begin
        idx = t - FIRST;
        model(c, ref_d[idx], ref_p[idx], l, r, o);
        chk("out_idx", int'(bus.OUT_IDX), idx);
        chk("left", int'(bus.LEFT), l);
        chk("right", int'(bus.RIGHT), r);
        chk("over", int'(bus.OVER), o);
        if (directed && idx < 5) begin
          chk("plan_left", int'(bus.LEFT), dir_l[idx]);
          chk("plan_right", int'(bus.RIGHT), dir_r[idx]);
          chk("plan_over", int'(bus.OVER), dir_o[idx]);
        end
        last_l = l; last_r = r; last_o = o;
      end
      if (t == FIRST + N) begin
        chk("hold_idx", int'(bus.OUT_IDX), N - 1);
        chk("hold_left", int'(bus.LEFT), last_l);
        chk("hold_right", int'(bus.RIGHT), last_r);
        chk("hold_over", int'(bus.OVER), last_o);
      end
      if (mode == 1 && t == FIRST + 100) begin
        START = 1'b1;
        CYCLE = 13'd2000;
      end else begin
        START = 1'b0;
      end
      if (mode == 2 && t == FIRST + 50) begin
        RST_N = 1'b0;
        #1;
        chk("abort_valid", int'(bus.OUT_VALID), 0);
        chk("abort_idx", int'(bus.OUT_IDX), 0);
        chk("abort_left", int'(bus.LEFT), 0);
        chk("abort_right", int'(bus.RIGHT), 0);
        chk("abort_over", int'(bus.OVER), 0);
        chk("abort_busy", int'(BUSY), 0);
        chk("abort_done", int'(DONE), 0);
        chk("abort_addr", int'(bus.RAM_ADDR), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("post_abort_busy", int'(BUSY), 0);
        chk("post_abort_done", int'(DONE), 0);
        chk("post_abort_valid", int'(bus.OUT_VALID), 0);
        return;
      end
      @(negedge CLK);
    end
  endtask

  int c_rand;

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    CYCLE = '0;
    repeat (3) @(negedge CLK);
    chk("rst_addr", int'(bus.RAM_ADDR), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_valid", int'(bus.OUT_VALID), 0);
    chk("rst_idx", int'(bus.OUT_IDX), 0);
    chk("rst_left", int'(bus.LEFT), 0);
    chk("rst_right", int'(bus.RIGHT), 0);
    chk("rst_over", int'(bus.OVER), 0);
    RST_N = 1'b1;
    @(negedge CLK);

    fill_directed();
    run_frame(4096, 0, 1'b1);

    fill_random(4096);
    run_frame(4096, 1, 1'b0);
    CYCLE = 13'd4096;

    fill_random(4096);
    run_frame(4096, 2, 1'b0);

    c_rand = $urandom_range(4096, 1000);
    fill_random(c_rand);
    run_frame(c_rand, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
